// File: rtl/rv32_wb_pkg.sv
// rv32_wb_pkg: result-select encodings and late-result entry type for writeback
package rv32_wb_pkg;
  localparam logic [2:0] RES_ALU = 3'd0;
  localparam logic [2:0] RES_MEM = 3'd1;
  localparam logic [2:0] RES_PC4 = 3'd2;
  localparam logic [2:0] RES_FPU = 3'd3;
  localparam logic [2:0] RES_CSR = 3'd4;
  typedef struct packed {
    logic        fp;
    logic [4:0]  rd;
    logic [31:0] data;
  } late_entry_t;
endpackage

// File: rtl/rv32_wb_late_fifo.sv
// rv32_wb_late_fifo: synchronous FIFO of late results with push/pop/full/empty
module rv32_wb_late_fifo
  import rv32_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        push_i,
  input  late_entry_t din_i,
  input  logic        pop_i,
  output late_entry_t dout_o,
  output logic        full_o,
  output logic        empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wp_q, rp_q;
  late_entry_t mem_q [DEPTH];
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (push_i) wp_q <= wp_q + (AW+1)'(1);
      if (pop_i) rp_q <= rp_q + (AW+1)'(1);
    end
  end
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wp_q[AW-1:0]] <= din_i;
  end
  always_comb begin
    dout_o  = mem_q[rp_q[AW-1:0]];
    empty_o = wp_q == rp_q;
    full_o  = (wp_q ^ rp_q) == {1'b1, {AW{1'b0}}};
  end
endmodule

// File: rtl/rv32_writeback.sv
// rv32_writeback: result mux, RF write-port arbitration with late FIFO, starvation stall, instret
module rv32_writeback
  import rv32_wb_pkg::*;
#(
  parameter int LATE_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        reg_write_i,
  input  logic        fp_reg_write_i,
  input  logic [2:0]  result_source_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] read_data_i,
  input  logic [31:0] pc_next_i,
  input  logic [31:0] fpu_result_i,
  input  logic [31:0] csr_data_i,
  input  logic [31:0] instr_i,
  input  logic        late_valid_i,
  output logic        late_ready_o,
  input  logic [4:0]  late_rd_i,
  input  logic        late_fp_i,
  input  logic [31:0] late_data_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_wd_o,
  output logic        fprf_we_o,
  output logic [4:0]  fprf_rd_o,
  output logic [31:0] fprf_wd_o,
  output logic        stall_o,
  output logic [63:0] instret_o
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [4:0]    rd;
  logic [31:0]   res;
  late_entry_t   late_in, head;
  logic          full, empty, push, pipe_int, pipe_fp, drain, drain_int, drain_fp, retire;
  logic [SW-1:0] starve_q, starve_d;
  logic [63:0]   instret_q, instret_d;
  rv32_wb_late_fifo #(.DEPTH(LATE_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (push),
    .din_i   (late_in),
    .pop_i   (drain),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );
  always_comb begin
    rd      = instr_i[11:7];
    res     = result_source_i == RES_ALU ? alu_result_i :
              result_source_i == RES_MEM ? read_data_i  :
              result_source_i == RES_PC4 ? pc_next_i    :
              result_source_i == RES_FPU ? fpu_result_i :
              result_source_i == RES_CSR ? csr_data_i   : 32'h0;
    late_in = '{fp: late_fp_i, rd: late_rd_i, data: late_data_i};
    push    = late_valid_i & !full;
    stall_o = !empty & (starve_q == SW'(STARVE_LIMIT));
    // integer wins when both write flags are set
    pipe_int  = reg_write_i & (rd != 5'd0) & !stall_o;
    pipe_fp   = fp_reg_write_i & !reg_write_i & !stall_o;
    drain     = !empty & (head.fp ? !pipe_fp : !pipe_int);
    // integer head targeting x0 pops without writing
    drain_int = drain & !head.fp & (head.rd != 5'd0);
    drain_fp  = drain & head.fp;
    retire    = (instr_i != 32'h0) & !stall_o;
    starve_d  = (empty | drain) ? '0 :
                starve_q == SW'(STARVE_LIMIT) ? starve_q : starve_q + SW'(1);
    instret_d = instret_q + 64'(retire);
  end
  always_comb begin
    late_ready_o = !full;
    rf_we_o      = rst_n_i & (pipe_int | drain_int);
    rf_rd_o      = pipe_int ? rd  : drain_int ? head.rd   : 5'd0;
    rf_wd_o      = pipe_int ? res : drain_int ? head.data : 32'h0;
    fprf_we_o    = rst_n_i & (pipe_fp | drain_fp);
    fprf_rd_o    = pipe_fp ? rd  : drain_fp ? head.rd   : 5'd0;
    fprf_wd_o    = pipe_fp ? res : drain_fp ? head.data : 32'h0;
    instret_o    = instret_q;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      starve_q  <= '0;
      instret_q <= '0;
    end else begin
      starve_q  <= starve_d;
      instret_q <= instret_d;
    end
  end
endmodule

// File: tb/tb_rv32_writeback.sv
// tb_rv32_writeback: directed and random checks of rv32_writeback against a queue-based model
module tb_rv32_writeback;
  localparam int LD = 2;
  localparam int SL = 4;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reg_write = 1'b0, fp_reg_write = 1'b0;
  logic [2:0]  src = 3'd0;
  logic [31:0] alu = '0, rdata = '0, pc4 = '0, fpu = '0, csr = '0, instr = '0;
  logic        late_valid = 1'b0, late_ready, late_fp = 1'b0;
  logic [4:0]  late_rd = '0;
  logic [31:0] late_data = '0;
  logic        rf_we, fprf_we, stall;
  logic [4:0]  rf_rd, fprf_rd;
  logic [31:0] rf_wd, fprf_wd;
  logic [63:0] instret;
  typedef struct {bit fp; bit [4:0] rd; bit [31:0] data;} ent_t;
  ent_t       q[$];
  int         starve;
  bit [63:0]  ret;
  int         n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  rv32_writeback #(.LATE_DEPTH(LD), .STARVE_LIMIT(SL)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .reg_write_i(reg_write), .fp_reg_write_i(fp_reg_write),
    .result_source_i(src), .alu_result_i(alu), .read_data_i(rdata), .pc_next_i(pc4),
    .fpu_result_i(fpu), .csr_data_i(csr), .instr_i(instr), .late_valid_i(late_valid),
    .late_ready_o(late_ready), .late_rd_i(late_rd), .late_fp_i(late_fp), .late_data_i(late_data),
    .rf_we_o(rf_we), .rf_rd_o(rf_rd), .rf_wd_o(rf_wd), .fprf_we_o(fprf_we), .fprf_rd_o(fprf_rd),
    .fprf_wd_o(fprf_wd), .stall_o(stall), .instret_o(instret)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    q.delete();
    starve = 0;
    ret = '0;
  endtask
  task automatic cycle();
    bit [4:0] rd;
    bit [31:0] res;
    bit st, pint, pfp, drain, ready, ewe, efwe, empty_pre;
    bit [4:0] erd, efrd;
    bit [31:0] ewd, efwd;
    @(negedge clk);
    rd = instr[11:7];
    case (src)
      3'd0: res = alu;
      3'd1: res = rdata;
      3'd2: res = pc4;
      3'd3: res = fpu;
      3'd4: res = csr;
      default: res = 32'h0;
    endcase
    st = q.size() != 0 && starve == SL;
    pint = reg_write && rd != 0 && !st;
    pfp = fp_reg_write && !reg_write && !st;
    drain = 1'b0;
    if (q.size() != 0) drain = q[0].fp ? !pfp : !pint;
    ewe = pint; erd = rd; ewd = res;
    efwe = pfp; efrd = rd; efwd = res;
    if (drain && !q[0].fp && q[0].rd != 0) begin ewe = 1'b1; erd = q[0].rd; ewd = q[0].data; end
    if (drain && q[0].fp) begin efwe = 1'b1; efrd = q[0].rd; efwd = q[0].data; end
    ready = q.size() < LD;
    chk("stall", stall, st);
    chk("late_ready", late_ready, ready);
    chk("rf_we", rf_we, ewe);
    chk("fprf_we", fprf_we, efwe);
    chk("instret", instret, ret);
    if (ewe) begin chk("rf_rd", rf_rd, erd); chk("rf_wd", rf_wd, ewd); end
    if (efwe) begin chk("fprf_rd", fprf_rd, efrd); chk("fprf_wd", fprf_wd, efwd); end
    @(posedge clk);
    empty_pre = q.size() == 0;
    if (drain) void'(q.pop_front());
    if (late_valid && ready) q.push_back('{late_fp, late_rd, late_data});
    starve = (empty_pre || drain) ? 0 : (starve < SL ? starve + 1 : SL);
    if (instr != 0 && !st) ret++;
    #1;
  endtask
  task automatic late(input bit v, input bit f, input bit [4:0] r, input bit [31:0] d);
    late_valid = v; late_fp = f; late_rd = r; late_data = d;
  endtask
  initial begin
    model_reset();
    #2;
    chk("rst_rf_we", rf_we, 0);
    chk("rst_fprf_we", fprf_we, 0);
    chk("rst_stall", stall, 0);
    chk("rst_ready", late_ready, 1);
    chk("rst_instret", instret, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    instr = 32'h00A00093; reg_write = 1'b1; src = 3'd0; alu = 32'h5;
    cycle();
    instr = 32'h00000193;
    rdata = 32'h11111111; pc4 = 32'h22222222; fpu = 32'h33333333; csr = 32'h44444444;
    for (int s = 1; s < 8; s++) begin src = 3'(s); cycle(); end
    instr = 32'h00000013; src = 3'd0;
    cycle();
    instr = 32'h00000293; alu = 32'hABCD0005;
    late(1, 1, 5'd4, 32'h3F800000);
    cycle();
    late(0, 0, 0, 0);
    cycle();
    late(1, 0, 5'd6, 32'h66);
    cycle();
    late(1, 0, 5'd7, 32'h77);
    cycle();
    late(0, 0, 0, 0);
    repeat (14) cycle();
    reg_write = 1'b0; instr = 32'h0;
    late(1, 0, 5'd0, 32'hDEAD);
    cycle();
    late(0, 0, 0, 0);
    repeat (2) cycle();
    reg_write = 1'b1; instr = 32'h00000293;
    late(1, 0, 5'd8, 32'h88); cycle();
    late(1, 0, 5'd9, 32'h99); cycle();
    late(0, 0, 0, 0); cycle();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_rf_we", rf_we, 0);
    chk("arst_fprf_we", fprf_we, 0);
    chk("arst_stall", stall, 0);
    chk("arst_ready", late_ready, 1);
    chk("arst_instret", instret, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    reg_write = 1'b0; instr = 32'h0;
    repeat (3) cycle();
    for (int i = 0; i < 600; i++) begin
      reg_write = $urandom_range(0, 3) != 0;
      fp_reg_write = $urandom_range(0, 3) == 0;
      src = 3'($urandom_range(0, 7));
      alu = $urandom; rdata = $urandom; pc4 = $urandom; fpu = $urandom; csr = $urandom;
      instr = $urandom_range(0, 7) == 0 ? 32'h0 : $urandom;
      late($urandom_range(0, 2) == 0, 1'($urandom), 5'($urandom), $urandom);
      cycle();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
